fft_sample_loader: RTL and testbench

// - Sits directly downstream of the clock divider, in the i_ref_clk domain.
// - Turns rising edges of the divided clock into one-cycle sample ticks.
// - On each tick, captures one serial input sample into a small FIFO.
// - Tags samples with FFT frame markers (first/last of FRAME_LEN) and streams them to the FFT core over valid/ready.

---
 rtl/fft_sample_loader.sv | 142 ++++++++++++++
 tb/tb_fft_sample_loader.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fft_sample_loader                                                 |
// | Desc   : Divided-clock rising-edge ticks capture samples into a small FIFO,|
// |          tagged with FFT frame first/last markers, streamed via valid/ready|
// |          Define FFT_LOADER_SYNC_EN to double-synchronise i_div_clk.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fft_sample_loader #(
  parameter int DATA_WD   = 16,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 32
) (
  input  logic                     i_ref_clk,
  input  logic                     i_rst,
  input  logic                     i_div_clk,
  input  logic                     i_enable,
  input  logic [DATA_WD-1:0]       i_data,
  input  logic                     i_ready,
  input  logic                     i_clr_ovf,
  output logic [DATA_WD-1:0]       o_data,
  output logic                     o_valid,
  output logic                     o_first,
  output logic                     o_last,
  output logic                     o_overflow,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int              c_aw       = $clog2(DEPTH);
  localparam int              c_iw       = $clog2(FRAME_LEN);
  localparam int              c_last_i   = FRAME_LEN - 1;
  localparam logic [c_aw:0]   c_full     = DEPTH[c_aw:0];
  localparam logic [c_aw:0]   c_lvl_one  = {{c_aw{1'b0}}, 1'b1};
  localparam logic [c_aw-1:0] c_ptr_one  = {{(c_aw-1){1'b0}}, 1'b1};
  localparam logic [c_iw-1:0] c_idx_one  = {{(c_iw-1){1'b0}}, 1'b1};
  localparam logic [c_iw-1:0] c_idx_last = c_last_i[c_iw-1:0];

  logic                r_s_cur;
  logic                r_s_prev;
  logic                w_tick;
  logic                w_push_req;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;

  logic [DATA_WD-1:0]  r_mem_data [DEPTH];
  logic [DEPTH-1:0]    r_mem_first;
  logic [DEPTH-1:0]    r_mem_last;
  logic [c_aw-1:0]     r_wr_ptr;
  logic [c_aw-1:0]     r_rd_ptr;
  logic [c_aw:0]       r_level;
  logic [c_iw-1:0]     r_idx;
  logic                r_ovf;

`ifdef FFT_LOADER_SYNC_EN
  logic                r_sync;

  // Two-flop synchroniser ahead of the edge detector for an unrelated source.
  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync   <= 1'b0;
      r_s_cur  <= 1'b0;
      r_s_prev <= 1'b0;
    end else begin
      r_sync   <= i_div_clk;
      r_s_cur  <= r_sync;
      r_s_prev <= r_s_cur;
    end
  end
`else
  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s_cur  <= 1'b0;
      r_s_prev <= 1'b0;
    end else begin
      r_s_cur  <= i_div_clk;
      r_s_prev <= r_s_cur;
    end
  end
`endif

  assign w_tick     = r_s_cur & ~r_s_prev;
  assign w_push_req = w_tick & i_enable;
  assign w_full     = (r_level == c_full);
  assign w_pop      = o_valid & i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & w_full & ~w_pop;

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_data[i] <= '0;
      end
      r_mem_first <= '0;
      r_mem_last  <= '0;
    end else if (w_push) begin
      r_mem_data[r_wr_ptr]  <= i_data;
      r_mem_first[r_wr_ptr] <= (r_idx == '0);
      r_mem_last[r_wr_ptr]  <= (r_idx == c_idx_last);
    end
  end

  always_ff @(posedge i_ref_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_idx    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
        r_idx    <= r_idx + c_idx_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_lvl_one;
        2'b01:   r_level <= r_level - c_lvl_one;
        default: r_level <= r_level;
      endcase
      // A drop coinciding with a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign o_data     = r_mem_data[r_rd_ptr];
  assign o_first    = r_mem_first[r_rd_ptr];
  assign o_last     = r_mem_last[r_rd_ptr];
  assign o_valid    = (r_level != '0);
  assign o_level    = r_level;
  assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fft_sample_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_fft_sample_loader                                              |
// | Desc   : Randomised bench for fft_sample_loader with a queue-based model.  |
// |          Honours FFT_LOADER_SYNC_EN for the tick delay.                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_fft_sample_loader;

  localparam int DEPTH     = 4;
  localparam int FRAME_LEN = 32;
`ifdef FFT_LOADER_SYNC_EN
  localparam int SYNC_D = 2;
`else
  localparam int SYNC_D = 1;
`endif

  typedef struct packed {
    logic [15:0] data;
    logic        first;
    logic        last;
  } ent_t;

  logic        i_ref_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_div_clk = 1'b0;
  logic        i_enable = 1'b1;
  logic [15:0] i_data = '0;
  logic        i_ready = 1'b0;
  logic        i_clr_ovf = 1'b0;
  logic [15:0] o_data;
  logic        o_valid;
  logic        o_first;
  logic        o_last;
  logic        o_overflow;
  logic [2:0]  o_level;
  logic [22:0] obs;

  int checks = 0;
  int errors = 0;

  ent_t mq[$];
  ent_t mdl_pops[$];
  ent_t dut_pops[$];
  int   m_idx = 0;
  logic m_ovf = 1'b0;
  logic [3:0] hist = '0;

  fft_sample_loader #(.DATA_WD(16), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
    .i_ref_clk (i_ref_clk),
    .i_rst     (i_rst),
    .i_div_clk (i_div_clk),
    .i_enable  (i_enable),
    .i_data    (i_data),
    .i_ready   (i_ready),
    .i_clr_ovf (i_clr_ovf),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_first   (o_first),
    .o_last    (o_last),
    .o_overflow(o_overflow),
    .o_level   (o_level)
  );

  always #5 i_ref_clk = ~i_ref_clk;

  assign obs = {o_valid, o_level, o_first, o_last, o_overflow, o_data};

  function automatic logic [22:0] exp_vec();
    logic [22:0] v;
    v = '0;
    v[22]    = (mq.size() != 0);
    v[21:19] = 3'(mq.size());
    v[16]    = m_ovf;
    if (mq.size() != 0) begin
      v[18]   = mq[0].first;
      v[17]   = mq[0].last;
      v[15:0] = mq[0].data;
    end
    return v;
  endfunction

  // Head fields are meaningless while empty, so only status bits are compared.
  function automatic logic [22:0] cmp_mask();
    return (mq.size() != 0) ? 23'h7fffff : 23'h790000;
  endfunction

  // A rise first seen at edge k yields a tick at edge k+SYNC_D.
  function automatic logic tick_next();
    return hist[SYNC_D-1] && !hist[SYNC_D];
  endfunction

  task automatic model_clear();
    mq.delete();
    m_idx = 0;
    m_ovf = 1'b0;
    hist  = '0;
  endtask

  task automatic cycle();
    logic tick;
    logic pop;
    logic drop;
    ent_t e;
    tick = tick_next();
    pop  = (mq.size() != 0) && i_ready;
    drop = 1'b0;
    if (o_valid && i_ready) dut_pops.push_back({o_data, o_first, o_last});
    if (pop) mdl_pops.push_back(mq.pop_front());
    if (tick && i_enable) begin
      if (mq.size() < DEPTH) begin
        e.data  = i_data;
        e.first = (m_idx == 0);
        e.last  = (m_idx == FRAME_LEN - 1);
        mq.push_back(e);
        m_idx = (m_idx + 1) % FRAME_LEN;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (i_clr_ovf) m_ovf = 1'b0;
    hist = {hist[2:0], i_div_clk};
    @(posedge i_ref_clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_div_clk = 1'b0;
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic drive_period(input int ratio, input logic [15:0] d);
    i_data = d;
    for (int c = 0; c < ratio; c++) begin
      i_div_clk = (c < ratio / 2);
      cycle();
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    i_div_clk = 1'b0;
    i_ready = 1'b0;
    i_enable = 1'b1;
    i_clr_ovf = 1'b0;
    model_clear();
    @(posedge i_ref_clk);
    #1;
    i_rst = 1'b1;
    dut_pops.delete();
    mdl_pops.delete();
  endtask

  task automatic test_reset();
    #2 i_rst = 1'b0;
    #1;
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", obs, 23'h0);
    end
    do_reset();
    idle(2);
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("FAIL reset_idle got %h want %h", obs, 23'h0);
    end
  endtask

  task automatic test_latency();
    int k;
    do_reset();
    i_ready = 1'b1;
    i_data  = 16'ha5a5;
    idle(2);
    i_div_clk = 1'b1;
    cycle();
    i_div_clk = 1'b0;
    k = 0;
    while (!o_valid && k < 10) begin
      cycle();
      k++;
    end
    checks++;
    if (k !== SYNC_D) begin
      errors++;
      $display("FAIL latency got %0d want %0d", k, SYNC_D);
    end
    idle(4);
    checks++;
    if (dut_pops.size() !== 1 || dut_pops[0] !== {16'ha5a5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL latency_sample got n=%0d want n=1 first sample a5a5/first", dut_pops.size());
    end
  endtask

  task automatic test_stream();
    do_reset();
    i_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      drive_period(4, 16'(p + 1));
      checks++;
      if ((obs & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
        errors++;
        $display("FAIL stream_state p=%0d got %h want %h", p, obs & cmp_mask(), exp_vec() & cmp_mask());
      end
    end
    idle(6);
    checks++;
    if (dut_pops.size() !== 20) begin
      errors++;
      $display("FAIL stream_count got %0d want 20", dut_pops.size());
    end
    for (int j = 0; j < dut_pops.size(); j++) begin
      checks++;
      if (dut_pops[j].data !== 16'(j + 1)) begin
        errors++;
        $display("FAIL stream_data j=%0d got %h want %h", j, dut_pops[j].data, 16'(j + 1));
      end
    end
  endtask

  task automatic test_frame_markers();
    do_reset();
    i_ready = 1'b1;
    for (int p = 0; p < 64; p++) drive_period(2, 16'(p + 1));
    idle(8);
    checks++;
    if (dut_pops.size() !== 64 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL frame_count got n=%0d ovf=%b want n=64 ovf=0", dut_pops.size(), o_overflow);
    end
    for (int j = 0; j < dut_pops.size() && j < 64; j++) begin
      checks++;
      if (dut_pops[j].first !== (j == 0 || j == 32) || dut_pops[j].last !== (j == 31 || j == 63)
          || dut_pops[j] !== mdl_pops[j]) begin
        errors++;
        $display("FAIL frame_marker j=%0d got %h want %h", j, dut_pops[j], mdl_pops[j]);
      end
    end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    for (int p = 0; p < 6; p++) drive_period(2, 16'(p + 1));
    idle(4);
    checks++;
    if (o_level !== 3'd4 || o_overflow !== 1'b1 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_full got lvl=%0d ovf=%b want lvl=4 ovf=1", o_level, o_overflow);
    end
    // Clear lands on the very edge of another drop: the flag must hold.
    i_div_clk = 1'b1;
    cycle();
    i_div_clk = 1'b0;
    n = 0;
    while (!tick_next() && n < 8) begin
      cycle();
      n++;
    end
    i_clr_ovf = 1'b1;
    cycle();
    i_clr_ovf = 1'b0;
    checks++;
    if (o_overflow !== 1'b1 || n >= 8) begin
      errors++;
      $display("FAIL ovf_clr_vs_drop got %b want 1", o_overflow);
    end
    i_clr_ovf = 1'b1;
    cycle();
    i_clr_ovf = 1'b0;
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b want 0", o_overflow);
    end
    i_ready = 1'b1;
    idle(6);
    checks++;
    if (dut_pops.size() !== 4 || o_level !== 3'd0) begin
      errors++;
      $display("FAIL ovf_drain got n=%0d lvl=%0d want n=4 lvl=0", dut_pops.size(), o_level);
    end
    // Index resumes at 4, so the 28th further sample closes the frame.
    for (int p = 0; p < 28; p++) drive_period(4, 16'(100 + p));
    idle(6);
    checks++;
    if (dut_pops.size() !== 32 || dut_pops[31].last !== 1'b1 || dut_pops[4].first !== 1'b0) begin
      errors++;
      $display("FAIL ovf_resume_idx got n=%0d want n=32 last on sample 32", dut_pops.size());
    end
  endtask

  task automatic test_full_pop();
    int n;
    do_reset();
    for (int p = 0; p < 4; p++) drive_period(4, 16'(p + 1));
    idle(4);
    i_div_clk = 1'b1;
    cycle();
    i_div_clk = 1'b0;
    n = 0;
    while (!tick_next() && n < 8) begin
      cycle();
      n++;
    end
    i_ready = 1'b1;
    cycle();
    i_ready = 1'b0;
    checks++;
    if (o_level !== 3'd4 || o_overflow !== 1'b0 || dut_pops.size() !== 1 || n >= 8) begin
      errors++;
      $display("FAIL full_pop got lvl=%0d ovf=%b pops=%0d want lvl=4 ovf=0 pops=1",
               o_level, o_overflow, dut_pops.size());
    end
  endtask

  task automatic test_enable();
    do_reset();
    i_ready = 1'b1;
    for (int p = 0; p < 5; p++) drive_period(4, 16'(p + 1));
    idle(4);
    i_enable = 1'b0;
    for (int p = 0; p < 10; p++) drive_period(4, 16'(50 + p));
    idle(4);
    checks++;
    if (dut_pops.size() !== 5 || o_level !== 3'd0) begin
      errors++;
      $display("FAIL enable_off got n=%0d lvl=%0d want n=5 lvl=0", dut_pops.size(), o_level);
    end
    i_enable = 1'b1;
    for (int p = 0; p < 27; p++) drive_period(4, 16'(200 + p));
    idle(6);
    checks++;
    if (dut_pops.size() !== 32 || dut_pops[31].last !== 1'b1 || dut_pops[5].first !== 1'b0) begin
      errors++;
      $display("FAIL enable_resume got n=%0d want n=32 last on sample 32", dut_pops.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_ready = 1'b1;
    for (int p = 0; p < 14; p++) drive_period(4, 16'(p + 1));
    idle(4);
    i_ready = 1'b0;
    for (int p = 0; p < 3; p++) drive_period(4, 16'(p + 40));
    idle(4);
    checks++;
    if (o_level !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_setup got lvl=%0d want 3", o_level);
    end
    i_rst = 1'b0;
    #1;
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h want %h", obs, 23'h0);
    end
    do_reset();
    i_ready = 1'b1;
    drive_period(4, 16'h0bad);
    idle(6);
    checks++;
    if (dut_pops.size() !== 1 || dut_pops[0].first !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_first got n=%0d want n=1 first=1", dut_pops.size());
    end
  endtask

  task automatic test_random();
    int ratio;
    do_reset();
    for (int p = 0; p < 80; p++) begin
      ratio    = $urandom_range(2, 6);
      i_data   = 16'($urandom);
      i_enable = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < ratio; c++) begin
        i_div_clk = (c < ratio / 2);
        i_ready   = ($urandom_range(0, 2) != 0);
        i_clr_ovf = ($urandom_range(0, 15) == 0);
        cycle();
        checks++;
        if ((obs & cmp_mask()) !== (exp_vec() & cmp_mask())) begin
          errors++;
          $display("FAIL random_state p=%0d c=%0d got %h want %h", p, c,
                   obs & cmp_mask(), exp_vec() & cmp_mask());
        end
      end
    end
    i_clr_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_frame_markers();
    test_overflow();
    test_full_pop();
    test_enable();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
